// File: rtl/lsu_defs.sv
// Shared load/store encodings, FSM states and access-size decode for the LSU alignment unit.
package lsu_defs;

    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LD  = 3'b011;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    localparam logic [2:0] INST_LWU = 3'b110;
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;
    localparam logic [2:0] INST_SD  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_WAIT0,
        ST_ISSUE1,
        ST_WAIT1,
        ST_RESP
    } state_t;

    function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

    // Doubleword and unsigned-word forms only exist on a 64-bit datapath.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3, input int xlen);
        if (we) begin
            return (funct3 == INST_SB) || (funct3 == INST_SH) || (funct3 == INST_SW) ||
                   ((funct3 == INST_SD) && (xlen == 64));
        end
        case (funct3)
            INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: return 1'b1;
            INST_LD, INST_LWU:                              return xlen == 64;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// Load lane extraction: shifts {beat1, beat0} down by the byte offset and sign/zero-extends.
// Purely combinational; no backpressure.
module lsu_extract
    import lsu_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]          data,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [2:0]                 funct3,
    output logic [XLEN-1:0]            result
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] shifted;
    logic [3:0]      nbytes;
    logic            sign;

    always_comb begin
        shifted = XLEN'(data >> {offset, 3'b000});
        nbytes  = access_bytes(funct3);
        // funct3[2] marks the unsigned load forms
        sign = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (!funct3[2] && (i + 1 == int'(nbytes))) sign = shifted[8*i+7];
        end
        result = '0;
        for (int i = 0; i < NB; i++) begin
            result[8*i +: 8] = (i < int'(nbytes)) ? shifted[8*i +: 8] : {8{sign}};
        end
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment between EX/MEM and data memory: byte-enable stores, extended loads.
// Latency: 3 cycles single beat, 5 split (LSU_MISALIGN_EN), 1 on error; req_ready only in IDLE.
// Backpressure: mem_req held until mem_gnt, response waits on mem_rvalid.
module lsu_align
    import lsu_defs::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam logic [2*NB-1:0]   BE_ONE  = {{(2*NB-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] NB_STEP = ADDR_W'(NB);

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   beat0_q;
    logic [XLEN-1:0]   rdata_q;
    logic [4:0]        rd_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic              beat1;
    logic [OW-1:0]     off;
    logic [3:0]        size;
    logic [ADDR_W-1:0] word_addr;
    logic [2*NB-1:0]   be_full;
    logic [2*XLEN-1:0] wdata_full;
    logic [2*XLEN-1:0] ext_data;
    logic [XLEN-1:0]   ext_rdata;

    assign off       = addr_q[OW-1:0];
    assign size      = access_bytes(f3_q);
    assign word_addr = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    // Double-width shifts: the low half is beat 0, the spill-over high half is beat 1.
    assign be_full    = ((BE_ONE << size) - BE_ONE) << off;
    assign wdata_full = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};

`ifdef LSU_MISALIGN_EN
    logic cross_q;
    assign cross_q = (int'(off) + int'(size)) > NB;
    assign req_err = !funct3_legal(req_we, req_funct3, XLEN);
`else
    logic req_cross;
    assign req_cross = (int'(req_addr[OW-1:0]) + int'(access_bytes(req_funct3))) > NB;
    assign req_err   = !funct3_legal(req_we, req_funct3, XLEN) || req_cross;
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = req_err ? ST_RESP : ST_ISSUE0;
            ST_ISSUE0: if (mem_gnt) state_d = ST_WAIT0;
`ifdef LSU_MISALIGN_EN
            ST_WAIT0:  if (mem_rvalid) state_d = cross_q ? ST_ISSUE1 : ST_RESP;
            ST_ISSUE1: if (mem_gnt) state_d = ST_WAIT1;
            ST_WAIT1:  if (mem_rvalid) state_d = ST_RESP;
`else
            ST_WAIT0:  if (mem_rvalid) state_d = ST_RESP;
`endif
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign ext_data = (state_q == ST_WAIT1) ? {mem_rdata, beat0_q} : {{XLEN{1'b0}}, mem_rdata};

    lsu_extract #(.XLEN(XLEN)) u_extract (
        .data   (ext_data),
        .offset (off),
        .funct3 (f3_q),
        .result (ext_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            beat0_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                err_q   <= req_err;
                rdata_q <= '0;
            end
            if (state_q == ST_WAIT0 && mem_rvalid) beat0_q <= mem_rdata;
            if (state_d == ST_RESP && state_q != ST_IDLE) rdata_q <= we_q ? '0 : ext_rdata;
        end
    end

    // Memory-side fields are zeroed whenever no request is outstanding.
    assign mem_req   = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);
    assign beat1     = (state_q == ST_ISSUE1);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = !mem_req ? '0 : (beat1 ? word_addr + NB_STEP : word_addr);
    assign mem_be    = !mem_req ? '0 : (beat1 ? be_full[2*NB-1:NB] : be_full[NB-1:0]);
    assign mem_wdata = !mem_req ? '0 : (beat1 ? wdata_full[2*XLEN-1:XLEN] : wdata_full[XLEN-1:0]);

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_rd    = rsp_valid ? rd_q : '0;
    assign rsp_err   = rsp_valid && err_q;

endmodule
